// File: rtl/fp16_sqrt_pkg.sv
// Shared types and constants for the fp16 square-root iteration core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp16_sqrt_pkg;

  localparam int MANT_W = 11;          // mantissa incl. hidden bit
  localparam int EXP_W  = 7;           // signed unbiased exponent
  localparam int ROOT_W = 12;          // 11 result bits + 1 guard bit
  localparam int RAD_W  = 2 * ROOT_W;  // radicand width
  localparam int REM_W  = ROOT_W + 2;  // partial remainder width

  localparam int BIAS = 15;

  localparam logic [MANT_W-1:0] QNAN_MANT = 11'h200;
  localparam logic [MANT_W-1:0] ONE_MANT  = 11'h400;
  // Exponent that pack turns into a zero encoding.
  localparam logic [EXP_W-1:0]  ZERO_EXP  = EXP_W'(-BIAS);

  typedef enum logic [2:0] {
    IDLE,
    SPEC,
    CALC,
    ROUND,
    OUT
  } state_t;

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root digit step: consumes two radicand bits, yields one root bit.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the caller samples it.
module sqrt_step
  import fp16_sqrt_pkg::*;
(
  input  logic [REM_W-1:0]  rem_in,
  input  logic [ROOT_W-1:0] root_in,
  input  logic [1:0]        pair_in,
  output logic [REM_W-1:0]  rem_out,
  output logic [ROOT_W-1:0] root_out
);

  logic [REM_W+1:0] rem_sh;
  logic [REM_W+1:0] trial;
  logic             ge;
  logic [REM_W-1:0] rem_sub;

  // Trial-subtract 4*root+1 from the shifted remainder; keep the difference if it fits.
  // The surviving remainder never exceeds 2*root, so the low REM_W bits carry it exactly.
  always_comb begin
    rem_sh   = {rem_in, pair_in};
    trial    = {2'b00, root_in, 2'b01};
    ge       = (rem_sh >= trial);
    rem_sub  = rem_sh[REM_W-1:0] - trial[REM_W-1:0];
    rem_out  = ge ? rem_sub : rem_sh[REM_W-1:0];
    root_out = {root_in[ROOT_W-2:0], ge};
  end

endmodule

// File: rtl/sqrt_iter.sv
// Multi-cycle fp16 square root (restoring recurrence + round-half-even) feeding pack.
// Latency: accept->it_valid 14 cycles normal (8 with SQRT_ITER_RADIX4_EN), 2 cycles special.
// Backpressure: n_ready only in IDLE; n_valid while busy is ignored, upstream must hold/retry.
// Build option: SQRT_ITER_RADIX4_EN retires two root bits per CALC cycle.
module sqrt_iter
  import fp16_sqrt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              n_valid,
  output logic              n_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mant_in,
  input  logic              is_zero_in,
  input  logic              is_nan_in,
  input  logic              is_pinf_in,
  input  logic              is_ninf_in,
  input  logic              result_in,
  output logic              it_valid,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_out,
  output logic              is_nan_out,
  output logic              is_pinf_out,
  output logic              is_ninf_out,
  output logic              result_out
);

`ifdef SQRT_ITER_RADIX4_EN
  localparam int         STEP_BITS = 4;
  localparam logic [3:0] CALC_LAST = 4'd5;
`else
  localparam int         STEP_BITS = 2;
  localparam logic [3:0] CALC_LAST = 4'd11;
`endif

  state_t state_q, state_d;
  logic   accept;
  logic   special_in;

  // Latched operand
  logic              sign_q, zero_q, nan_q, pinf_q, ninf_q, tag_q;
  logic [MANT_W-1:0] mant_q;
  logic [EXP_W-1:0]  exp_q;

  // Recurrence state
  logic [RAD_W-1:0]  rad_q;
  logic [REM_W-1:0]  rem_q, rem_nx;
  logic [ROOT_W-1:0] root_q, root_nx;
  logic [3:0]        cnt_q;

  // Staged result, copied to the outputs in OUT
  logic              res_sign, res_nan, res_pinf;
  logic [EXP_W-1:0]  res_exp;
  logic [MANT_W-1:0] res_mant;

  // Operand preparation: fold an odd exponent into the radicand so e is even.
  logic signed [EXP_W-1:0] exp_s, exp_e, exp_half;
  logic [RAD_W-1:0]        radicand;

  assign exp_s      = $signed(exp_in);
  assign exp_e      = exp_in[0] ? (exp_s - 7'sd1) : exp_s;
  assign exp_half   = exp_e >>> 1;
  assign radicand   = exp_in[0] ? {mant_in, 13'b0} : {1'b0, mant_in, 12'b0};
  assign special_in = is_zero_in | is_nan_in | is_pinf_in | is_ninf_in | sign_in;

  // Rounding: guard bit is root_q[0]; ties go to even on root_q[1].
  logic              sticky, rnd_inc;
  logic [ROOT_W-1:0] rnd_sum;

  assign sticky  = |rem_q;
  assign rnd_inc = root_q[0] & (sticky | root_q[1]);
  assign rnd_sum = {1'b0, root_q[ROOT_W-1:1]} + {{(ROOT_W-1){1'b0}}, rnd_inc};

  // A negative root never survives classification, so this flag stays low.
  assign is_ninf_out = 1'b0;

`ifdef SQRT_ITER_RADIX4_EN
  logic [REM_W-1:0]  rem_mid;
  logic [ROOT_W-1:0] root_mid;

  sqrt_step u_step_hi (
    .rem_in   (rem_q),
    .root_in  (root_q),
    .pair_in  (rad_q[RAD_W-1:RAD_W-2]),
    .rem_out  (rem_mid),
    .root_out (root_mid)
  );

  sqrt_step u_step_lo (
    .rem_in   (rem_mid),
    .root_in  (root_mid),
    .pair_in  (rad_q[RAD_W-3:RAD_W-4]),
    .rem_out  (rem_nx),
    .root_out (root_nx)
  );
`else
  sqrt_step u_step (
    .rem_in   (rem_q),
    .root_in  (root_q),
    .pair_in  (rad_q[RAD_W-1:RAD_W-2]),
    .rem_out  (rem_nx),
    .root_out (root_nx)
  );
`endif

  // State register; enable low acts as a synchronous abort to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       state_q <= IDLE;
    else if (!enable) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d = state_q;
    n_ready = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        n_ready = enable;
        accept  = n_valid & enable;
        if (accept) state_d = special_in ? SPEC : CALC;
      end
      SPEC:  state_d = OUT;
      CALC:  if (cnt_q == CALC_LAST) state_d = ROUND;
      ROUND: state_d = OUT;
      OUT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, recurrence iteration and result staging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      nan_q    <= 1'b0;
      pinf_q   <= 1'b0;
      ninf_q   <= 1'b0;
      tag_q    <= 1'b0;
      mant_q   <= '0;
      exp_q    <= '0;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      res_sign <= 1'b0;
      res_nan  <= 1'b0;
      res_pinf <= 1'b0;
      res_exp  <= '0;
      res_mant <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sign_q <= sign_in;
            zero_q <= is_zero_in;
            nan_q  <= is_nan_in;
            pinf_q <= is_pinf_in;
            ninf_q <= is_ninf_in;
            tag_q  <= result_in;
            mant_q <= mant_in;
            exp_q  <= exp_half;
            rad_q  <= radicand;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
          end
        end
        CALC: begin
          rad_q  <= rad_q << STEP_BITS;
          rem_q  <= rem_nx;
          root_q <= root_nx;
          cnt_q  <= cnt_q + 4'd1;
        end
        SPEC: begin
          res_sign <= 1'b0;
          res_nan  <= 1'b0;
          res_pinf <= 1'b0;
          res_exp  <= '0;
          res_mant <= '0;
          if (nan_q) begin
            res_nan  <= 1'b1;
            res_sign <= sign_q;
            res_mant <= mant_q;
          end else if ((sign_q & ~zero_q) | ninf_q) begin
            res_nan  <= 1'b1;
            res_mant <= QNAN_MANT;
          end else if (pinf_q) begin
            res_pinf <= 1'b1;
          end else begin
            // Only zero remains: sqrt(+-0) = +-0.
            res_sign <= sign_q;
            res_exp  <= ZERO_EXP;
          end
        end
        ROUND: begin
          res_sign <= 1'b0;
          res_nan  <= 1'b0;
          res_pinf <= 1'b0;
          // Carry out of the rounder means the root reached 2.0.
          res_mant <= rnd_sum[ROOT_W-1] ? ONE_MANT : rnd_sum[MANT_W-1:0];
          res_exp  <= rnd_sum[ROOT_W-1] ? (exp_q + 7'd1) : exp_q;
        end
        default: ;
      endcase
    end
  end

  // Output register: loads once per result and holds until the next OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      it_valid    <= 1'b0;
      sign_out    <= 1'b0;
      exp_out     <= '0;
      mant_out    <= '0;
      is_nan_out  <= 1'b0;
      is_pinf_out <= 1'b0;
      result_out  <= 1'b0;
    end else if (!enable) begin
      it_valid    <= 1'b0;
      sign_out    <= 1'b0;
      exp_out     <= '0;
      mant_out    <= '0;
      is_nan_out  <= 1'b0;
      is_pinf_out <= 1'b0;
      result_out  <= 1'b0;
    end else begin
      it_valid <= 1'b0;
      if (state_q == OUT) begin
        it_valid    <= 1'b1;
        sign_out    <= res_sign;
        exp_out     <= res_exp;
        mant_out    <= res_mant;
        is_nan_out  <= res_nan;
        is_pinf_out <= res_pinf;
        result_out  <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_sqrt_iter.sv
// Self-checking bench for sqrt_iter against an arithmetic reference model.
// Latency: checks accept->it_valid spacing for normal and special operands.
// Backpressure: checks n_ready drop while busy and that held n_valid is ignored.
module tb_sqrt_iter;

`ifdef SQRT_ITER_RADIX4_EN
  localparam int LAT_N = 8;
`else
  localparam int LAT_N = 14;
`endif
  localparam int LAT_S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        n_valid = 1'b0;
  logic        n_ready;
  logic        sign_in = 1'b0;
  logic [6:0]  exp_in = '0;
  logic [10:0] mant_in = '0;
  logic        is_zero_in = 1'b0, is_nan_in = 1'b0, is_pinf_in = 1'b0, is_ninf_in = 1'b0;
  logic        result_in = 1'b0;
  logic        it_valid, sign_out, is_nan_out, is_pinf_out, is_ninf_out, result_out;
  logic [6:0]  exp_out;
  logic [10:0] mant_out;

  int errs   = 0;
  int checks = 0;

  typedef struct packed {
    logic        sign;
    logic [6:0]  exp;
    logic [10:0] mant;
    logic        nan;
    logic        pinf;
    logic        spec;
  } res_t;

  sqrt_iter dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .n_valid(n_valid), .n_ready(n_ready),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
    .is_zero_in(is_zero_in), .is_nan_in(is_nan_in),
    .is_pinf_in(is_pinf_in), .is_ninf_in(is_ninf_in),
    .result_in(result_in),
    .it_valid(it_valid), .sign_out(sign_out), .exp_out(exp_out), .mant_out(mant_out),
    .is_nan_out(is_nan_out), .is_pinf_out(is_pinf_out), .is_ninf_out(is_ninf_out),
    .result_out(result_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: special-case table, then floor sqrt of the scaled mantissa and
  // round-half-even on the 12th root bit using the exact remainder.
  function automatic res_t model(input logic s, input int e, input logic [10:0] m,
                                 input logic [3:0] fl);
    res_t   r;
    longint rad, q, rem;
    int     ee, mm;
    r = '0;
    r.spec = |fl | s;
    if (fl[2]) begin
      r.nan = 1'b1; r.sign = s; r.mant = m;
    end else if ((s && !fl[3]) || fl[0]) begin
      r.nan = 1'b1; r.mant = 11'h200;
    end else if (fl[1]) begin
      r.pinf = 1'b1;
    end else if (fl[3]) begin
      r.sign = s; r.exp = 7'(-15);
    end else begin
      ee = e;
      if (ee % 2 != 0) begin
        rad = longint'(m) * 8192;
        ee  = ee - 1;
      end else begin
        rad = longint'(m) * 4096;
      end
      q = longint'($rtoi($sqrt(real'(rad))));
      while (q * q > rad) q--;
      while ((q + 1) * (q + 1) <= rad) q++;
      rem = rad - q * q;
      mm  = int'(q / 2);
      ee  = ee / 2;
      if ((q % 2 == 1) && (rem != 0 || ((q / 2) % 2 == 1))) mm++;
      if (mm == 2048) begin mm = 1024; ee++; end
      r.mant = 11'(mm);
      r.exp  = 7'(ee);
    end
    return r;
  endfunction

  // Present an operand and return just after the edge that accepts it.
  task automatic start_op(input logic s, input int e, input logic [10:0] m,
                          input logic [3:0] fl, input logic tg);
    @(negedge clk);
    sign_in = s; exp_in = 7'(e); mant_in = m; result_in = tg;
    {is_zero_in, is_nan_in, is_pinf_in, is_ninf_in} = fl;
    n_valid = 1'b1;
    for (int i = 0; i < 50 && !n_ready; i++) @(negedge clk);
    chk("accept_ready", 32'(n_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // fl = {zero, nan, pinf, ninf}
  task automatic run_op(input string tag, input logic s, input int e, input logic [10:0] m,
                        input logic [3:0] fl, input logic tg);
    res_t r;
    int   lat;
    bit   seen;
    r = model(s, e, m, fl);
    start_op(s, e, m, fl, tg);
    n_valid = 1'b0;
    chk({tag, "_busy"}, 32'(n_ready), 32'd0);
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (it_valid) begin seen = 1; break; end
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(r.spec ? LAT_S : LAT_N));
    chk({tag, "_exp"}, 32'(exp_out), 32'(r.exp));
    chk({tag, "_mant"}, 32'(mant_out), 32'(r.mant));
    chk({tag, "_flags"}, 32'({sign_out, is_nan_out, is_pinf_out, is_ninf_out, result_out}),
        32'({r.sign, r.nan, r.pinf, 1'b0, tg}));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(it_valid), 32'd0);
  endtask

  task automatic quiet_window(input string tag);
    int pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (it_valid) pulses++;
    end
    chk(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    int   busy, e;
    bit   seen;
    logic s;

    // Reset state
    #12;
    chk("rst_valid", 32'(it_valid), 32'd0);
    chk("rst_out", 32'({sign_out, exp_out, mant_out, is_nan_out, is_pinf_out, result_out}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(n_ready), 32'd1);

    // Directed points
    run_op("one", 1'b0, 0, 11'h400, 4'b0000, 1'b1);
    chk("one_const", 32'({exp_out, mant_out}), 32'({7'd0, 11'h400}));
    run_op("four", 1'b0, 2, 11'h400, 4'b0000, 1'b0);
    chk("four_const", 32'({exp_out, mant_out}), 32'({7'd1, 11'h400}));
    run_op("two", 1'b0, 1, 11'h400, 4'b0000, 1'b1);
    chk("two_const", 32'({exp_out, mant_out}), 32'({7'd0, 11'h5A8}));
    run_op("neg", 1'b1, 0, 11'h400, 4'b0000, 1'b0);
    chk("neg_const", 32'({sign_out, is_nan_out, mant_out}), 32'({1'b0, 1'b1, 11'h200}));
    run_op("nzero", 1'b1, 0, 11'h000, 4'b1000, 1'b1);
    chk("nzero_const", 32'({sign_out, exp_out, mant_out}), 32'({1'b1, 7'h71, 11'h000}));
    run_op("pzero", 1'b0, 0, 11'h000, 4'b1000, 1'b0);
    run_op("pinf",  1'b0, 0, 11'h000, 4'b0010, 1'b1);
    run_op("ninf",  1'b1, 0, 11'h000, 4'b0001, 1'b0);
    run_op("nan",   1'b1, 5, 11'h123, 4'b0100, 1'b1);
    run_op("maxodd", 1'b0, 15, 11'h7FF, 4'b0000, 1'b0);
    run_op("maxeven", 1'b0, 14, 11'h7FF, 4'b0000, 1'b1);
    run_op("minexp", 1'b0, -24, 11'h401, 4'b0000, 1'b0);
    run_op("negodd", 1'b0, -23, 11'h555, 4'b0000, 1'b1);

    // Randomized operands
    for (int n = 0; n < 30; n++) begin
      s = ($urandom_range(7) == 0);
      e = int'($urandom_range(39)) - 24;
      run_op("rand", s, e, {1'b1, 10'($urandom)}, 4'b0000, 1'($urandom));
    end

    // n_valid held while busy: second operand must be ignored
    start_op(1'b0, 0, 11'h400, 4'b0000, 1'b0);
    mant_in = 11'h600;
    exp_in  = 7'd3;
    busy = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (it_valid) begin seen = 1; n_valid = 1'b0; break; end
      if (!n_ready) busy++;
      @(posedge clk); #1;
    end
    n_valid = 1'b0;
    chk("hold_seen", 32'(seen), 32'd1);
    chk("hold_busy", 32'(busy), 32'(LAT_N));
    chk("hold_first", 32'({exp_out, mant_out}), 32'({7'd0, 11'h400}));
    quiet_window("hold_extra");

    // Reset mid-CALC
    start_op(1'b0, 3, 11'h500, 4'b0000, 1'b1);
    n_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(it_valid), 32'd0);
    chk("arst_out", 32'({sign_out, exp_out, mant_out, is_nan_out, is_pinf_out, result_out}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    quiet_window("arst_quiet");
    run_op("post_rst", 1'b0, 3, 11'h500, 4'b0000, 1'b1);

    // Enable low mid-CALC
    start_op(1'b0, -5, 11'h6A3, 4'b0000, 1'b0);
    n_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #1;
    chk("en_out", 32'({it_valid, sign_out, exp_out, mant_out, result_out}), 32'd0);
    chk("en_ready", 32'(n_ready), 32'd0);
    @(negedge clk) enable = 1'b1;
    quiet_window("en_quiet");
    run_op("post_en", 1'b0, -5, 11'h6A3, 4'b0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

endmodule

// File: doc/sqrt_iter.md
Name: sqrt_iter

Overview:
Multi-cycle fp16 square-root core sitting directly upstream of the pack stage. Accepts an unpacked operand (sign, unbiased exponent, normalized 11-bit mantissa with hidden bit, special flags) from the normalize/special stage. Computes a rounded 11-bit root by restoring digit recurrence. Emits a one-cycle it_valid with the unpacked result for pack to encode.

Parameters:
MANT_W, 11, mantissa width including hidden bit (mant[10] = 1 for normal operands)
EXP_W, 7, signed unbiased exponent width
ROOT_W, 12, root bits computed (11 result bits + 1 guard bit)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  synchronous soft clear; low forces IDLE and zeroes outputs
n_valid  in  1  operand valid from upstream
n_ready  out  1  high in IDLE; operand accepted on n_valid & n_ready
sign_in  in  1  operand sign
exp_in  in  7  signed unbiased exponent, range -24..15
mant_in  in  11  normalized mantissa, mant_in[10] = 1 unless zero
is_zero_in / is_nan_in / is_pinf_in / is_ninf_in  in  1 each  operand class flags
result_in  in  1  sideband tag, carried through unchanged
it_valid  out  1  one-cycle result strobe to pack
sign_out  out  1  result sign
exp_out  out  7  signed unbiased result exponent
mant_out  out  11  result mantissa
is_nan_out / is_pinf_out / is_ninf_out  out  1 each  result class flags
result_out  out  1  registered copy of result_in

Behaviour:
- Reset (rst_n low, async) and enable low (sync): state = IDLE; all outputs 0; n_ready = 1 after reset release.
- States:
  - IDLE: on accept, latch inputs. Special class → SPEC; otherwise → CALC.
  - SPEC: classify → OUT.
  - CALC: one root bit per cycle, 12 cycles → ROUND.
  - ROUND: → OUT.
  - OUT: it_valid = 1 for exactly one cycle → IDLE.
- Special results, priority order:
  - NaN in → NaN out with sign and mant passed through.
  - Negative nonzero, including -inf → is_nan_out = 1, sign 0, mant_out = 11'h200 (pack encodes 0x7E00).
  - +inf → is_pinf_out = 1.
  - Zero → sign preserved, exp_out = -15, mant_out = 0 (pack encodes ±0).
- Normal exponent: if exp_in is odd, radicand = {mant_in, 13'b0} and e = exp_in - 1; else radicand = {1'b0, mant_in, 12'b0} and e = exp_in. exp_out = e >>> 1 (range -12..7).
- Recurrence: 24-bit radicand, restoring; 14-bit partial remainder; 12-bit root Q, MSB first.
- Rounding: sticky = remainder != 0; increment Q[11:1] if Q[0] & (sticky | Q[1]). On carry out (root = 2.0): mant_out = 11'h400, exp_out + 1.
- Latency from accept edge to it_valid: normal 14 cycles; special 2 cycles. Throughput is one operand per latency plus 1 cycle (IDLE).
- n_valid while n_ready = 0 is ignored; upstream must hold or retry.
- enable low or rst_n low mid-CALC aborts the operation with no it_valid.
- Outputs hold their last values after the it_valid pulse until the next OUT.

Optional Feature:
SQRT_ITER_RADIX4_EN: when defined, CALC retires 2 root bits per cycle (6 cycles); normal latency becomes 8 cycles; results are bit-identical. When undefined, the radix-2 path with 12 CALC cycles is used.

Decomposition:
- Shared package fp16_sqrt_pkg: state enum (IDLE, SPEC, CALC, ROUND, OUT), BIAS = 15, QNAN_MANT = 11'h200, width constants.
- One sub-module, sqrt_step: combinational single-bit restoring step (remainder, root in → remainder, root out). It is instantiated twice under SQRT_ITER_RADIX4_EN.

Test Plan:
- exp 0, mant 11'h400 (1.0) → exp_out 0, mant_out 11'h400; it_valid exactly 14 cycles after accept.
- exp 2, mant 11'h400 (4.0) → exp_out 1, mant_out 11'h400 (pack 0x4000).
- exp 1, mant 11'h400 (2.0) → exp_out 0, mant_out 11'h5A8 (pack 0x3DA8).
- sign 1, exp 0, mant 11'h400 → is_nan_out 1, sign_out 0, mant_out 11'h200; it_valid after 2 cycles. is_zero_in with sign 1 → sign_out 1, exp_out -15, mant 0.
- n_valid held high while busy → only the first operand processed; n_ready low for 14 cycles.
- rst_n pulsed low in CALC cycle 5 → outputs 0 immediately; no it_valid; next operand processes correctly.
